// File: rtl/mux_n_to_1_scan.sv
// Registered N-to-1 multiplexer with a valid/ready output stage and optional auto-scan.
// Define MUX_SCAN_EN to add the mode port and the round-robin scan counter.
module mux_n_to_1_scan #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*WIDTH-1:0]     a,
  input  logic [$clog2(N)-1:0]   s,
`ifdef MUX_SCAN_EN
  input  logic                   mode,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out,
  output logic [$clog2(N)-1:0]   out_ch,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int SEL_W = $clog2(N);
  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(N);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               xfer_p0;
  logic [SEL_W-1:0]   ch_p0;
  logic               in_range_p0;
  logic [WIDTH-1:0]   data_p0;

  function automatic logic [WIDTH-1:0] pick_channel(input logic [N*WIDTH-1:0] v,
                                                    input logic [SEL_W-1:0]   idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SEL_W'(k)) r = v[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign xfer_p0   = in_valid && in_ready;

`ifdef MUX_SCAN_EN
  logic [SEL_W-1:0] scan_cnt;

  assign ch_p0 = mode ? scan_cnt : s;

  // Wraps at N-1 so the scanned index is always a real channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (xfer_p0 && mode) begin
      scan_cnt <= (scan_cnt == SEL_W'(N - 1)) ? '0 : scan_cnt + 1'b1;
    end
  end
`else
  assign ch_p0 = s;
`endif

  assign in_range_p0 = ({1'b0, ch_p0} < CH_LIM);
  assign data_p0     = in_range_p0 ? pick_channel(a, ch_p0) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer_p0) state_d = FULL;
      FULL:    if (!xfer_p0 && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // p0 -> output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= '0;
      out_ch  <= '0;
      out_err <= 1'b0;
    end else if (xfer_p0) begin
      out     <= data_p0;
      out_ch  <= ch_p0;
      out_err <= !in_range_p0;
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// Scoreboard bench for mux_n_to_1_scan (N=4 main instance, N=3 instance for out-of-range).
// Scan scenarios are exercised when MUX_SCAN_EN is defined.
module tb_mux_n_to_1_scan;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [1:0]  s = '0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [7:0]  out;
  logic [1:0]  out_ch;
  logic        out_err;
  logic        out_valid;

  logic [23:0] a3 = '0;
  logic [1:0]  s3 = '0;
  logic        mode3 = 1'b0;
  logic        iv3 = 1'b0;
  logic        or3 = 1'b0;
  logic        ir3;
  logic [7:0]  out3;
  logic [1:0]  ch3;
  logic        err3;
  logic        ov3;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  bit   exp_valid = 1'b0;
  logic [1:0] exp_scan = 2'd0;

  mux_n_to_1_scan #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst(rst), .a(a), .s(s),
`ifdef MUX_SCAN_EN
    .mode(mode),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_ch(out_ch),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_to_1_scan #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .a(a3), .s(s3),
`ifdef MUX_SCAN_EN
    .mode(mode3),
`endif
    .in_valid(iv3), .in_ready(ir3), .out(out3), .out_ch(ch3),
    .out_err(err3), .out_valid(ov3), .out_ready(or3)
  );

  // Advances one clock; the reference model decides at the falling edge whether
  // the coming rising edge transfers, and pushes the expected capture.
  task automatic step(output bit xfer);
    logic [1:0] ch;
    exp_t e;
    @(negedge clk);
    xfer = in_valid && (!exp_valid || out_ready);
    ch = s;
`ifdef MUX_SCAN_EN
    if (mode) ch = exp_scan;
`endif
    if (xfer) begin
      e.d = a[int'(ch)*8 +: 8];
      e.ch = ch;
      e.err = 1'b0;
      q.push_back(e);
`ifdef MUX_SCAN_EN
      if (mode) exp_scan = (exp_scan == 2'd3) ? 2'd0 : exp_scan + 2'd1;
`endif
      exp_valid = 1'b1;
    end else if (exp_valid && out_ready) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_tests++;
    if ({out_valid, out, out_ch, out_err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async_outputs: got %h expected 000", {out_valid, out, out_ch, out_err});
    end
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 32'h44332211;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_held_over_edge: got valid=%b out=%h expected valid=0 out=00", out_valid, out);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_manual;
    bit   x;
    exp_t e;
    logic [1:0] sels [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    a = 32'h44332211;
    in_valid = 1'b1;
    out_ready = 1'b1;
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = sels[i];
      step(x);
      n_tests++;
      if (!x || q.size() == 0) begin
        n_fail++;
        $display("FAIL manual_xfer_%0d: got no transfer expected transfer", i);
      end else begin
        e = q.pop_front();
        if ({out_valid, out, out_ch, out_err} !== {1'b1, e.d, e.ch, e.err}) begin
          n_fail++;
          $display("FAIL manual_sel_%0d: got v=%b out=%h ch=%0d err=%b expected v=1 out=%h ch=%0d err=%b",
                   i, out_valid, out, out_ch, out_err, e.d, e.ch, e.err);
        end
      end
      if (i == 0) begin
        n_tests++;
        if (out !== 8'h33 || out_ch !== 2'd2) begin
          n_fail++;
          $display("FAIL manual_s2_const: got out=%h ch=%0d expected out=33 ch=2", out, out_ch);
        end
      end
    end
    in_valid = 1'b0;
    step(x);
    n_tests++;
    if (out_valid !== 1'b0 || out !== 8'h22 || out_ch !== 2'd1 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_hold: got v=%b out=%h ch=%0d err=%b expected v=0 out=22 ch=1 err=0",
               out_valid, out, out_ch, out_err);
    end
    out_ready = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_backpressure;
    bit   x;
    exp_t e;
    a = 32'h44332211;
    s = 2'd1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step(x);
    if (q.size() != 0) e = q.pop_front();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s = 2'(i);
      a = $urandom;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready);
      end
      step(x);
      n_tests++;
      if ({out_valid, out, out_ch, out_err} !== {1'b1, 8'h22, 2'd1, 1'b0} || q.size() != 0) begin
        n_fail++;
        $display("FAIL bp_stable_%0d: got v=%b out=%h ch=%0d err=%b expected v=1 out=22 ch=1 err=0",
                 i, out_valid, out, out_ch, out_err);
      end
    end
    a = 32'hA4B3C2D1;
    s = 2'd3;
    out_ready = 1'b1;
    step(x);
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL bp_release: got no transfer expected transfer");
    end else begin
      e = q.pop_front();
      if ({out_valid, out, out_ch} !== {1'b1, e.d, e.ch}) begin
        n_fail++;
        $display("FAIL bp_release: got v=%b out=%h ch=%0d expected v=1 out=%h ch=%0d",
                 out_valid, out, out_ch, e.d, e.ch);
      end
    end
    in_valid = 1'b0;
    step(x);
  endtask

  task automatic test_back_to_back;
    bit   x;
    exp_t e;
    logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    a = 32'hD4C3B2A1;
    in_valid = 1'b1;
    out_ready = 1'b1;
`ifdef MUX_SCAN_EN
    mode = 1'b1;
`endif
    for (int i = 0; i < 6; i++) begin
`ifdef MUX_SCAN_EN
      s = 2'($urandom);
`else
      s = seq[i];
`endif
      step(x);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_xfer_%0d: got no transfer expected transfer", i);
      end else begin
        e = q.pop_front();
        if ({out_valid, out, out_ch, out_err} !== {1'b1, e.d, seq[i], 1'b0}) begin
          n_fail++;
          $display("FAIL b2b_seq_%0d: got v=%b out=%h ch=%0d expected v=1 out=%h ch=%0d",
                   i, out_valid, out, out_ch, e.d, seq[i]);
        end
      end
    end
`ifdef MUX_SCAN_EN
    mode = 1'b0;
    s = 2'd3;
    step(x);
    if (q.size() != 0) e = q.pop_front();
    n_tests++;
    if (out_ch !== 2'd3 || out !== 8'hD4) begin
      n_fail++;
      $display("FAIL scan_manual_mix: got out=%h ch=%0d expected out=d4 ch=3", out, out_ch);
    end
    mode = 1'b1;
    step(x);
    if (q.size() != 0) e = q.pop_front();
    n_tests++;
    if (out_ch !== 2'd2 || out !== 8'hC3) begin
      n_fail++;
      $display("FAIL scan_resume: got out=%h ch=%0d expected out=c3 ch=2", out, out_ch);
    end
    mode = 1'b0;
`endif
    in_valid = 1'b0;
    step(x);
  endtask

  task automatic test_out_of_range;
    logic [1:0]  sel3 [3] = '{2'd3, 2'd2, 2'd0};
    logic [11:0] want [3] = '{{8'h00, 2'd3, 1'b1, 1'b1}, {8'h33, 2'd2, 1'b0, 1'b1}, {8'h11, 2'd0, 1'b0, 1'b1}};
    a3 = 24'h332211;
    iv3 = 1'b1;
    or3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s3 = sel3[i];
      @(posedge clk);
      #1;
      n_tests++;
      if ({out3, ch3, err3, ov3} !== want[i]) begin
        n_fail++;
        $display("FAIL oor_n3_%0d: got out=%h ch=%0d err=%b v=%b expected %h", i, out3, ch3, err3, ov3, want[i]);
      end
    end
    iv3 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset;
    bit   x;
    exp_t e;
    a = 32'h44332211;
    s = 2'd3;
    in_valid = 1'b1;
    out_ready = 1'b1;
`ifdef MUX_SCAN_EN
    mode = 1'b1;
`endif
    step(x);
    if (q.size() != 0) e = q.pop_front();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, out, out_ch, out_err} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b out=%h ch=%0d err=%b expected all zero", out_valid, out, out_ch, out_err);
    end
`ifdef MUX_SCAN_EN
    n_tests++;
    if (dut.scan_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset_scan: got %0d expected 0", dut.scan_cnt);
    end
`endif
    q.delete();
    exp_valid = 1'b0;
    exp_scan = 2'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    s = 2'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(x);
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL post_reset_xfer: got no transfer expected transfer");
    end else begin
      e = q.pop_front();
      if ({out_valid, out, out_ch} !== {1'b1, e.d, e.ch}) begin
        n_fail++;
        $display("FAIL post_reset_xfer: got v=%b out=%h ch=%0d expected v=1 out=%h ch=%0d",
                 out_valid, out, out_ch, e.d, e.ch);
      end
    end
    in_valid = 1'b0;
    mode = 1'b0;
    step(x);
  endtask

  initial begin
    test_reset;
    test_manual;
    test_backpressure;
    test_back_to_back;
    test_out_of_range;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
